ddr_rw_scheduler: RTL and testbench



---
 rtl/ddr_rw_scheduler_if.sv | 25 ++
 rtl/ddr_rw_scheduler.sv | 159 +++++++++++++++
 tb/tb_ddr_rw_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rw_scheduler_if.sv
// Handshake bundle between ddr_rw_scheduler, the AXIS FIFO status flags and the MIG command port.
// The master modport is the scheduler side (drives rd_en/wr_en); slave is the MIG/FIFO side.
interface ddr_rw_scheduler_if;
  logic       init_calib_complete;
  logic       app_rdy;
  logic       app_wdf_rdy;
  logic       wr_req_valid;
  logic       rd_req_pending;
  logic [7:0] rd_fifo_free;
  logic       rd_return;
  logic       rd_en;
  logic       wr_en;

  modport master (
    input  init_calib_complete, app_rdy, app_wdf_rdy, wr_req_valid,
           rd_req_pending, rd_fifo_free, rd_return,
    output rd_en, wr_en
  );

  modport slave (
    output init_calib_complete, app_rdy, app_wdf_rdy, wr_req_valid,
           rd_req_pending, rd_fifo_free, rd_return,
    input  rd_en, wr_en
  );
endinterface

// File: rtl/ddr_rw_scheduler.sv
// DDR3 read/write turn scheduler: bounded bursts, turnaround gap, read credits, write starvation guard.
// Enables are combinational from registered state; app_rdy/app_wdf_rdy stall issue. Stats: DDR_SCHED_STATS_EN.
module ddr_rw_scheduler #(
  parameter int RD_BURST_MAX    = 32,
  parameter int WR_BURST_MAX    = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TURN_CYCLES     = 2,
  parameter int STARVE_LIMIT    = 256
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  ddr_rw_scheduler_if.master        bus,
  output logic [2:0]                sched_state,
  output logic                      credit_err,
  output logic [31:0]               stat_rd_cmds,
  output logic [31:0]               stat_wr_cmds,
  output logic [15:0]               stat_turns
);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int BURST_TOP = (RD_BURST_MAX > WR_BURST_MAX) ? RD_BURST_MAX : WR_BURST_MAX;
  localparam int BURST_W   = $clog2(BURST_TOP + 1);
  localparam int STARVE_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_READ      = 3'd2,
    S_WRITE     = 3'd3,
    S_TURN      = 3'd4
  } state_t;

  state_t              state, state_nxt;
  state_t              turn_tgt, turn_tgt_nxt;
  logic [BURST_W-1:0]  burst;
  logic [OUT_W-1:0]    outstanding;
  logic [STARVE_W-1:0] starve_cnt;
  logic [3:0]          turn_cnt;
  logic                rd_ok, rd_exit, wr_full;
  logic                rd_fire, wr_fire, turn_entry;

  assign rd_ok = bus.rd_req_pending
              && (outstanding < OUT_W'(MAX_OUTSTANDING))
              && (8'(outstanding) < bus.rd_fifo_free);

  assign rd_exit = (burst == BURST_W'(RD_BURST_MAX)) || (starve_cnt >= STARVE_W'(STARVE_LIMIT));
  assign wr_full = (burst == BURST_W'(WR_BURST_MAX));

  // Enables are masked in the cycle a turn ends so the last allowed slot is never overshot.
  assign bus.rd_en = (state == S_READ)  && rd_ok && !rd_exit;
  assign bus.wr_en = (state == S_WRITE) && bus.wr_req_valid && !wr_full;

  assign rd_fire     = bus.rd_en && bus.app_rdy;
  assign wr_fire     = bus.wr_en && bus.app_rdy && bus.app_wdf_rdy;
  assign turn_entry  = (state_nxt == S_TURN) && (state != S_TURN);
  assign sched_state = state;

  always_comb begin
    state_nxt    = state;
    turn_tgt_nxt = turn_tgt;
    case (state)
      S_WAIT_INIT: if (bus.init_calib_complete) state_nxt = S_IDLE;
      S_IDLE: begin
        if (rd_ok)                 state_nxt = S_READ;
        else if (bus.wr_req_valid) state_nxt = S_WRITE;
      end
      S_READ: begin
        if (rd_exit || (!rd_ok && bus.wr_req_valid)) begin
          state_nxt    = S_TURN;
          turn_tgt_nxt = S_WRITE;
        end else if (!rd_ok) begin
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (rd_ok && (wr_full || !bus.wr_req_valid)) begin
          state_nxt    = S_TURN;
          turn_tgt_nxt = S_READ;
        end else if (!bus.wr_req_valid) begin
          state_nxt = S_IDLE;
        end
      end
      S_TURN: if (turn_cnt == 4'(TURN_CYCLES - 1)) state_nxt = turn_tgt;
      default: state_nxt = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= S_WAIT_INIT;
      turn_tgt <= S_READ;
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      turn_tgt <= turn_tgt_nxt;
      if (turn_entry)          turn_cnt <= '0;
      else if (state == S_TURN) turn_cnt <= turn_cnt + 1'b1;
    end
  end

  // A full write burst with no read demand restarts the burst in place.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      burst <= '0;
    end else if (state_nxt != state) begin
      burst <= '0;
    end else if ((state == S_WRITE) && wr_full) begin
      burst <= '0;
    end else if (rd_fire || wr_fire) begin
      burst <= burst + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      starve_cnt <= '0;
    end else if ((state_nxt == S_WRITE) && (state != S_WRITE)) begin
      starve_cnt <= '0;
    end else if (bus.wr_req_valid && (state != S_WRITE) &&
                 (starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // A return with nothing outstanding is a lost credit: flag it and keep the count at zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      outstanding <= '0;
      credit_err  <= 1'b0;
    end else begin
      case ({rd_fire, bus.rd_return})
        2'b10: outstanding <= outstanding + 1'b1;
        2'b01: begin
          if (outstanding == '0) credit_err  <= 1'b1;
          else                   outstanding <= outstanding - 1'b1;
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef DDR_SCHED_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_rd_cmds <= '0;
      stat_wr_cmds <= '0;
      stat_turns   <= '0;
    end else begin
      if (rd_fire) stat_rd_cmds <= stat_rd_cmds + 32'd1;
      if (wr_fire) stat_wr_cmds <= stat_wr_cmds + 32'd1;
      if (turn_entry && (stat_turns != 16'hFFFF)) stat_turns <= stat_turns + 16'd1;
    end
  end
`else
  assign stat_rd_cmds = '0;
  assign stat_wr_cmds = '0;
  assign stat_turns   = '0;
`endif

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Bench for ddr_rw_scheduler: scoreboarded command/turn sequence, credits, starvation and async reset.
`timescale 1ns/1ps
module tb_ddr_rw_scheduler;
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

`ifdef DDR_SCHED_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  ddr_rw_scheduler_if b();
  ddr_rw_scheduler_if bs();

  logic [2:0]  st, st_s;
  logic        cerr, cerr_s;
  logic [31:0] s_rd, s_wr, s_rd_s, s_wr_s;
  logic [15:0] s_turns, s_turns_s;

  ddr_rw_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(b), .sched_state(st), .credit_err(cerr),
    .stat_rd_cmds(s_rd), .stat_wr_cmds(s_wr), .stat_turns(s_turns)
  );

  ddr_rw_scheduler #(.STARVE_LIMIT(16)) dut_s (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bs), .sched_state(st_s), .credit_err(cerr_s),
    .stat_rd_cmds(s_rd_s), .stat_wr_cmds(s_wr_s), .stat_turns(s_turns_s)
  );

  int checks = 0;
  int failures = 0;
  int max_out = 0;
  int out_cnt = 0;
  int wr_seen = 0;
  logic auto_ret = 1'b1;
  logic man_ret = 1'b0;
  logic [3:0] sr_m = '0;
  logic [3:0] sr_s = '0;
  byte exp_q[$];

  // MIG read-return model: each fire comes back 4 cycles later (auto) or on a manual pulse.
  initial begin
    logic fm;
    b.rd_return  = 1'b0;
    bs.rd_return = 1'b0;
    forever begin
      @(negedge clk_in);
      #1;
      if (rst_in) begin
        sr_m = '0; sr_s = '0; out_cnt = 0;
        b.rd_return = 1'b0; bs.rd_return = 1'b0;
      end else begin
        fm = b.rd_en && b.app_rdy;
        b.rd_return = auto_ret ? sr_m[3] : man_ret;
        sr_m = auto_ret ? {sr_m[2:0], fm} : 4'b0;
        out_cnt = out_cnt + int'(fm) - int'(b.rd_return);
        if (out_cnt > max_out) max_out = out_cnt;
        bs.rd_return = sr_s[3];
        sr_s = {sr_s[2:0], bs.rd_en && bs.app_rdy};
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    b.init_calib_complete  = 1'b0;
    bs.init_calib_complete = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    b.init_calib_complete = 1'b1; b.rd_req_pending = 1'b1; b.wr_req_valid = 1'b1;
    repeat (2) @(negedge clk_in);
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", st); end
    checks++; if (b.rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", b.rd_en); end
    checks++; if (b.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b want=0", b.wr_en); end
    checks++; if (cerr !== 1'b0) begin failures++; $display("FAIL reset_credit_err got=%b want=0", cerr); end
    checks++; if (s_rd !== 32'd0) begin failures++; $display("FAIL reset_stat_rd got=%0d want=0", s_rd); end
    checks++; if (s_wr !== 32'd0) begin failures++; $display("FAIL reset_stat_wr got=%0d want=0", s_wr); end
    checks++; if (s_turns !== 16'd0) begin failures++; $display("FAIL reset_stat_turns got=%0d want=0", s_turns); end
  endtask

  task automatic test_init();
    int bad = 0;
    int left_init = 0;
    int nf = 0;
    b.init_calib_complete = 1'b0; b.wr_req_valid = 1'b0; b.rd_req_pending = 1'b1;
    auto_ret = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) begin
      @(negedge clk_in);
      if (st !== 3'd0 || b.rd_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL wait_init_hold bad_cycles=%0d want=0", bad); end
    b.init_calib_complete = 1'b1;
    @(negedge clk_in);
    checks++; if (st !== 3'd1) begin failures++; $display("FAIL init_to_idle got=%0d want=1", st); end
    @(negedge clk_in);
    checks++; if (st !== 3'd2 || b.rd_en !== 1'b1) begin
      failures++; $display("FAIL idle_to_read state=%0d rd_en=%b want 2/1", st, b.rd_en);
    end
    if (b.rd_en && b.app_rdy) nf++;
    b.init_calib_complete = 1'b0;
    max_out = 0;
    repeat (150) begin
      @(negedge clk_in);
      if (st == 3'd0) left_init++;
      if (b.rd_en && b.app_rdy) nf++;
    end
    @(negedge clk_in);
    checks++; if (left_init != 0) begin failures++; $display("FAIL init_drop_effect wait_init_cycles=%0d want=0", left_init); end
    checks++; if (max_out > 8 || max_out < 1) begin failures++; $display("FAIL outstanding_peak got=%0d want 1..8", max_out); end
    checks++; if (s_rd !== (STATS_ON ? 32'(nf) : 32'd0)) begin
      failures++; $display("FAIL stat_rd_running got=%0d want=%0d", s_rd, STATS_ON ? nf : 0);
    end
  endtask

  task automatic test_burst_turn();
    byte ev, exp;
    int cyc = 0;
    do_reset();
    auto_ret = 1'b1;
    b.init_calib_complete = 1'b1; b.wr_req_valid = 1'b1; b.rd_req_pending = 1'b1;
    b.rd_fifo_free = 8'd64;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back("R");
    exp_q.push_back("T"); exp_q.push_back("T"); exp_q.push_back("W");
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      if (st == 3'd2 && b.rd_en)        ev = "R";
      else if (st == 3'd4)              ev = (b.rd_en || b.wr_en) ? "X" : "T";
      else if (st == 3'd3)              ev = b.wr_en ? "W" : "w";
      else if (b.rd_en || b.wr_en)      ev = "E";
      else                              ev = "N";
      if (ev != "N") begin
        exp = exp_q.pop_front();
        checks++;
        if (ev !== exp) begin
          failures++; $display("FAIL burst_seq left=%0d got=%c want=%c", exp_q.size(), ev, exp);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL burst_seq_timeout pending=%0d want=0", exp_q.size()); end
    wr_seen = (b.wr_en && b.app_rdy && b.app_wdf_rdy) ? 1 : 0;
    checks++; if (s_rd !== (STATS_ON ? 32'd32 : 32'd0)) begin failures++; $display("FAIL stat_rd_burst got=%0d want=%0d", s_rd, STATS_ON ? 32 : 0); end
    checks++; if (s_turns !== (STATS_ON ? 16'd1 : 16'd0)) begin failures++; $display("FAIL stat_turns got=%0d want=%0d", s_turns, STATS_ON ? 1 : 0); end
  endtask

  task automatic test_reset_mid_write();
    int wc = wr_seen;
    repeat (5) begin
      @(negedge clk_in);
      if (b.wr_en && b.app_rdy && b.app_wdf_rdy) wc++;
    end
    @(negedge clk_in);
    checks++; if (st !== 3'd3 || b.wr_en !== 1'b1) begin failures++; $display("FAIL pre_reset_write state=%0d wr_en=%b want 3/1", st, b.wr_en); end
    checks++; if (s_wr !== (STATS_ON ? 32'(wc) : 32'd0)) begin failures++; $display("FAIL stat_wr_count got=%0d want=%0d", s_wr, STATS_ON ? wc : 0); end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (b.wr_en !== 1'b0) begin failures++; $display("FAIL async_rst_wr_en got=%b want=0", b.wr_en); end
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL async_rst_state got=%0d want=0", st); end
    checks++; if (s_wr !== 32'd0) begin failures++; $display("FAIL async_rst_stat_wr got=%0d want=0", s_wr); end
  endtask

  task automatic test_credit();
    int nf = 0;
    int found = 0;
    int drop = 0;
    auto_ret = 1'b0; man_ret = 1'b0;
    b.wr_req_valid = 1'b0; b.rd_req_pending = 1'b1; b.rd_fifo_free = 8'd3;
    do_reset();
    b.init_calib_complete = 1'b1;
    repeat (20) begin @(negedge clk_in); if (b.rd_en && b.app_rdy) nf++; end
    checks++; if (nf != 3) begin failures++; $display("FAIL fifo_free3_fires got=%0d want=3", nf); end
    checks++; if (b.rd_en !== 1'b0) begin failures++; $display("FAIL fifo_free3_block rd_en=%b want=0", b.rd_en); end
    man_ret = 1'b1;
    @(negedge clk_in);
    man_ret = 1'b0;
    nf = 0;
    repeat (10) begin @(negedge clk_in); if (b.rd_en && b.app_rdy) nf++; end
    checks++; if (nf != 1) begin failures++; $display("FAIL one_return_one_fire got=%0d want=1", nf); end
    b.rd_fifo_free = 8'd5;
    nf = 0;
    repeat (10) begin @(negedge clk_in); if (b.rd_en && b.app_rdy) nf++; end
    checks++; if (nf != 2) begin failures++; $display("FAIL fill_to_five got=%0d want=2", nf); end
    // Outstanding is 5; a fire paired with a return must leave room for exactly one more.
    b.rd_fifo_free = 8'd6;
    nf = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk_in);
      if (b.rd_en) found = 1;
    end
    if (found != 0) begin
      man_ret = 1'b1; nf = 1;
      @(negedge clk_in);
      man_ret = 1'b0;
      if (b.rd_en) nf++;
      repeat (8) begin @(negedge clk_in); if (b.rd_en) nf++; end
    end
    checks++; if (nf != 2) begin failures++; $display("FAIL same_cycle_fire_return fires=%0d want=2", nf); end
    b.rd_req_pending = 1'b0;
    @(negedge clk_in);
    man_ret = 1'b1;
    repeat (6) @(negedge clk_in);
    man_ret = 1'b0;
    @(negedge clk_in);
    checks++; if (cerr !== 1'b0) begin failures++; $display("FAIL credit_err_early got=%b want=0", cerr); end
    man_ret = 1'b1;
    @(negedge clk_in);
    man_ret = 1'b0;
    checks++; if (cerr !== 1'b1) begin failures++; $display("FAIL credit_err_set got=%b want=1", cerr); end
    repeat (5) begin @(negedge clk_in); if (cerr !== 1'b1) drop++; end
    checks++; if (drop != 0) begin failures++; $display("FAIL credit_err_sticky low_cycles=%0d want=0", drop); end
  endtask

  task automatic test_starve();
    int nf = 0;
    int cyc = 0;
    int tc = 0;
    do_reset();
    checks++; if (cerr !== 1'b0) begin failures++; $display("FAIL credit_err_reset got=%b want=0", cerr); end
    bs.init_calib_complete = 1'b1; bs.rd_req_pending = 1'b1; bs.wr_req_valid = 1'b0;
    bs.rd_fifo_free = 8'd64;
    while (st_s != 3'd2 && cyc < 20) begin @(negedge clk_in); cyc++; end
    repeat (5) @(negedge clk_in);
    bs.wr_req_valid = 1'b1;
    cyc = 0;
    while (st_s == 3'd2 && cyc < 100) begin
      if (bs.rd_en && bs.app_rdy) nf++;
      @(negedge clk_in);
      cyc++;
    end
    checks++; if (nf != 16) begin failures++; $display("FAIL starve_read_fires got=%0d want=16", nf); end
    checks++; if (st_s !== 3'd4) begin failures++; $display("FAIL starve_exit_turn got=%0d want=4", st_s); end
    while (st_s == 3'd4 && tc < 20) begin
      if (bs.rd_en || bs.wr_en) tc = 100;
      tc++;
      @(negedge clk_in);
    end
    checks++; if (tc != 2) begin failures++; $display("FAIL starve_turn_len got=%0d want=2", tc); end
    checks++; if (st_s !== 3'd3 || bs.wr_en !== 1'b1) begin
      failures++; $display("FAIL starve_to_write state=%0d wr_en=%b want 3/1", st_s, bs.wr_en);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    b.init_calib_complete = 1'b0; b.app_rdy = 1'b1; b.app_wdf_rdy = 1'b1;
    b.wr_req_valid = 1'b0; b.rd_req_pending = 1'b0; b.rd_fifo_free = 8'd64;
    bs.init_calib_complete = 1'b0; bs.app_rdy = 1'b1; bs.app_wdf_rdy = 1'b1;
    bs.wr_req_valid = 1'b0; bs.rd_req_pending = 1'b0; bs.rd_fifo_free = 8'd64;
    test_reset();
    test_init();
    test_burst_turn();
    test_reset_mid_write();
    test_credit();
    test_starve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
